// File: rtl/boxcar_yc_separator.sv
// Runtime-configurable boxcar luma/chroma separator: running-sum moving average
// (luma) and centre-minus-average (chroma). Optional macro BOXCAR_ROUND_EN rounds luma half up.
module boxcar_yc_separator #(
  parameter int DATA_WIDTH    = 12,
  parameter int MAX_TAPS      = 32,
  parameter int FRAC_BITS     = 16,
  parameter int DEFAULT_TAPS  = 21,
  parameter int DEFAULT_RECIP = 3121
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_load,
  input  logic [$clog2(MAX_TAPS+1)-1:0]  cfg_taps,
  input  logic [FRAC_BITS:0]             cfg_recip,
  input  logic                           in_valid,
  input  logic signed [DATA_WIDTH-1:0]   in_data,
  output logic                           out_valid,
  output logic signed [DATA_WIDTH-1:0]   luma_out,
  output logic signed [DATA_WIDTH-1:0]   chroma_out,
  output logic                           filling
);
  localparam int TW = $clog2(MAX_TAPS+1);
  localparam int IW = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;
  localparam int AW = DATA_WIDTH + $clog2(MAX_TAPS) + 1;
  localparam int PW = AW + FRAC_BITS + 2;
  localparam int SW = PW - FRAC_BITS;
  localparam logic signed [SW-1:0] L_MAX = SW'((2**(DATA_WIDTH-1)) - 1);
  localparam logic signed [SW-1:0] L_MIN = SW'(-(2**(DATA_WIDTH-1)));

  typedef enum logic {FILL, RUN} state_t;

  state_t                       state;
  logic [TW-1:0]                n, cnt, cnt_next, taps_clamped;
  logic [FRAC_BITS:0]           recip;
  logic signed [AW-1:0]         acc, old, x_ext;
  logic                         vld_s1;
  logic signed [DATA_WIDTH-1:0] dly [MAX_TAPS];
  logic signed [DATA_WIDTH-1:0] dly_old, centre;
  logic [IW-1:0]                old_idx, ctr_idx;

  // Delay line is deliberately unreset; the fill count masks stale contents.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      dly[0] <= in_data;
      for (int i = 1; i < MAX_TAPS; i++) dly[i] <= dly[i-1];
    end
  end

  always_comb begin
    taps_clamped = cfg_taps;
    if (cfg_taps == '0) taps_clamped = TW'(1);
    else if (cfg_taps > TW'(MAX_TAPS)) taps_clamped = TW'(MAX_TAPS);
  end

  assign old_idx  = IW'(n - 1'b1);
  assign ctr_idx  = IW'((n - 1'b1) >> 1);
  assign dly_old  = dly[old_idx];
  assign centre   = dly[ctr_idx];
  assign x_ext    = {{(AW-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
  assign old      = (state == RUN) ? {{(AW-DATA_WIDTH){dly_old[DATA_WIDTH-1]}}, dly_old} : '0;
  assign cnt_next = (cnt < n) ? cnt + 1'b1 : n;
  assign filling  = (state == FILL);

  // Stage 1: running sum, fill tracking, window state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FILL;
      n      <= TW'(DEFAULT_TAPS);
      recip  <= (FRAC_BITS+1)'(DEFAULT_RECIP);
      acc    <= '0;
      cnt    <= '0;
      vld_s1 <= 1'b0;
    end else if (cfg_load) begin
      // A sample arriving with the load opens the new window.
      n      <= taps_clamped;
      recip  <= cfg_recip;
      acc    <= in_valid ? x_ext : '0;
      cnt    <= in_valid ? TW'(1) : '0;
      vld_s1 <= in_valid && (taps_clamped == TW'(1));
      state  <= (in_valid && (taps_clamped == TW'(1))) ? RUN : FILL;
    end else if (in_valid) begin
      acc    <= acc + x_ext - old;
      cnt    <= cnt_next;
      vld_s1 <= (cnt_next == n);
      if (cnt_next == n) state <= RUN;
    end else begin
      vld_s1 <= 1'b0;
    end
  end

  logic signed [PW-1:0]         acc_p, recip_p, prod, prod_r;
  logic signed [SW-1:0]         lwide;
  logic signed [DATA_WIDTH-1:0] luma_sat, chroma_sat;
  logic signed [DATA_WIDTH:0]   cwide;

  assign acc_p   = {{(PW-AW){acc[AW-1]}}, acc};
  assign recip_p = {{(PW-FRAC_BITS-1){1'b0}}, recip};
  assign prod    = acc_p * recip_p;
`ifdef BOXCAR_ROUND_EN
  assign prod_r  = prod + (PW'(1) <<< (FRAC_BITS-1));
`else
  assign prod_r  = prod;
`endif
  // Dropping the fraction bits is the floor arithmetic shift.
  assign lwide   = prod_r[PW-1:FRAC_BITS];

  always_comb begin
    if (lwide > L_MAX)      luma_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (lwide < L_MIN) luma_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                    luma_sat = lwide[DATA_WIDTH-1:0];
  end

  assign cwide = {centre[DATA_WIDTH-1], centre} - {luma_sat[DATA_WIDTH-1], luma_sat};

  always_comb begin
    if (cwide[DATA_WIDTH] != cwide[DATA_WIDTH-1])
      chroma_sat = cwide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      chroma_sat = cwide[DATA_WIDTH-1:0];
  end

  // Stage 2: registered, held outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      luma_out   <= '0;
      chroma_out <= '0;
    end else begin
      out_valid <= vld_s1;
      if (vld_s1) begin
        luma_out   <= luma_sat;
        chroma_out <= chroma_sat;
      end
    end
  end
endmodule

// File: tb/tb_boxcar_yc_separator.sv
// Bench for boxcar_yc_separator: window-queue reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_boxcar_yc_separator;
  localparam int DW = 12;

  logic clk = 1'b0, rst = 1'b1, cfg_load = 1'b0, in_valid = 1'b0;
  logic [5:0] cfg_taps = '0;
  logic [16:0] cfg_recip = '0;
  logic signed [DW-1:0] in_data = '0;
  logic signed [DW-1:0] luma_out, chroma_out;
  logic out_valid, filling;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  boxcar_yc_separator dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_taps(cfg_taps),
    .cfg_recip(cfg_recip), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .luma_out(luma_out), .chroma_out(chroma_out),
    .filling(filling)
  );

  // Reference: newest sample at the front, window truncated to N.
  int hist[$];
  int m_n, m_r;
  bit pend, ev;
  int pl, pc, el, ec;
  int cap_l[$], cap_c[$];

  function automatic int sat(longint v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return int'(v);
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_n = 21; m_r = 3121;
    pend = 0; ev = 0; el = 0; ec = 0;
  endtask

  task automatic model_edge(bit ld, int taps, int r, bit v, int d);
    longint sum, p;
    int l;
    ev = pend;
    if (pend) begin el = pl; ec = pc; end
    pend = 0;
    if (ld) begin
      m_n = (taps == 0) ? 1 : (taps > 32) ? 32 : taps;
      m_r = r;
      hist.delete();
    end
    if (v) begin
      hist.push_front(d);
      if (hist.size() > m_n) void'(hist.pop_back());
      if (hist.size() == m_n) begin
        sum = 0;
        foreach (hist[i]) sum += hist[i];
        p = sum * m_r;
`ifdef BOXCAR_ROUND_EN
        p += 32768;
`endif
        l = sat(p >>> 16);
        pl = l;
        pc = sat(longint'(hist[(m_n-1)/2]) - l);
        pend = 1;
      end
    end
  endtask

  task automatic step(bit v = 0, int d = 0, bit ld = 0, int taps = 0, int r = 0);
    in_valid = v; in_data = 12'(d); cfg_load = ld;
    cfg_taps = 6'(taps); cfg_recip = 17'(r);
    @(posedge clk);
    model_edge(ld, taps, r, v, d);
    @(negedge clk);
    in_valid = 0; cfg_load = 0;
    if (out_valid) begin
      cap_l.push_back(int'(luma_out));
      cap_c.push_back(int'(chroma_out));
    end
  endtask

  function automatic int xs(int i);
    return ((i * 37) % 400) - 200;
  endfunction

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("out_valid", int'(out_valid), int'(ev));
    chk("luma_out", int'(luma_out), el);
    chk("chroma_out", int'(chroma_out), ec);
    chk("filling", int'(filling), int'(hist.size() < m_n));
  end

  initial begin
    int prev, s;
    int a_l[$], a_c[$];
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_luma", int'(luma_out), 0);
    chk("rst_chroma", int'(chroma_out), 0);
    chk("rst_filling", int'(filling), 1);
    #2 rst = 0;
    @(negedge clk);

    // 21 samples of 1000 at default config
    for (int i = 0; i < 21; i++) begin
      step(1, 1000);
      if (i < 20) chk("t1_filling_early", int'(filling), 1);
    end
    chk("t1_filling_done", int'(filling), 0);
    chk("t1_no_out_yet", int'(out_valid), 0);
    step();
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_luma", int'(luma_out), 1000);
    chk("t1_chroma", int'(chroma_out), 0);

    // Load with a sample while a result is in stage 1
    step(1, 1000);
    step(1, 100, 1, 4, 16384);
    chk("t4_prev_out", int'(out_valid), 1);
    step(1, 200);
    chk("t4_dropped", int'(out_valid), 0);
    step(1, 300);
    step(1, 400);
    chk("t4_not_yet", int'(out_valid), 0);
    step();
    chk("t4_valid", int'(out_valid), 1);
    chk("t4_luma", int'(luma_out), 250);
    chk("t4_chroma", int'(chroma_out), 50);

    // N=2 alternating +/-500
    step(0, 0, 1, 2, 32768);
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      s = (i % 2 == 0) ? 500 : -500;
      step(1, s);
      if (i >= 2) begin
        chk("t2_valid", int'(out_valid), 1);
        chk("t2_luma", int'(luma_out), 0);
        chk("t2_chroma", int'(chroma_out), prev);
      end
      prev = s;
    end

    // N=1 with oversized reciprocal: saturation
    step(0, 0, 1, 1, 131071);
    step(1, 2047);
    step();
    chk("t3_luma_pos", int'(luma_out), 2047);
    chk("t3_chroma_pos", int'(chroma_out), 0);
    step(1, -2048);
    step();
    chk("t3_luma_neg", int'(luma_out), -2048);
    chk("t3_chroma_neg", int'(chroma_out), 0);

    // Tap clamping: 0 -> 1, 40 -> 32
    step(0, 0, 1, 0, 65536);
    step(1, 7);
    step();
    chk("clamp0_valid", int'(out_valid), 1);
    chk("clamp0_luma", int'(luma_out), 7);
    step(0, 0, 1, 40, 2048);
    for (int i = 0; i < 32; i++) begin
      step(1, 64);
      if (i == 30) chk("clamp40_fill31", int'(filling), 1);
    end
    chk("clamp40_fill32", int'(filling), 0);
    step();
    chk("clamp40_luma", int'(luma_out), 64);

    // N=3, 1,1,0: rounding sensitivity
    step(0, 0, 1, 3, 21845);
    step(1, 1); step(1, 1); step(1, 0);
    step();
`ifdef BOXCAR_ROUND_EN
    chk("t6_luma", int'(luma_out), 1);
    chk("t6_chroma", int'(chroma_out), 0);
`else
    chk("t6_luma", int'(luma_out), 0);
    chk("t6_chroma", int'(chroma_out), 1);
`endif

    // Same stream with and without input gaps
    step(0, 0, 1, 21, 3121);
    cap_l.delete(); cap_c.delete();
    for (int i = 0; i < 25; i++) step(1, xs(i));
    step();
    a_l = cap_l; a_c = cap_c;
    step(0, 0, 1, 21, 3121);
    cap_l.delete(); cap_c.delete();
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(1, 5)) step();
      step(1, xs(i));
    end
    step();
    chk("t5_count_nogap", a_l.size(), 5);
    chk("t5_count_gap", cap_l.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < a_l.size() && i < cap_l.size()) begin
        chk("t5_luma_seq", cap_l[i], a_l[i]);
        chk("t5_chroma_seq", cap_c[i], a_c[i]);
      end
    end

    // Reset mid-stream with a result pending
    step(0, 0, 1, 4, 16384);
    for (int i = 0; i < 4; i++) step(1, 300);
    #2 rst = 1;
    #1;
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_luma", int'(luma_out), 0);
    chk("mrst_filling", int'(filling), 1);
    model_reset();
    @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    step(); step();
    chk("mrst_lost", int'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
